piso_serial_tx: RTL and testbench
=================================

Name: piso_serial_tx

Overview:
- Parallel-in, serial-out framed transmitter. It is the transmit end of the team's flip-flop-based serial link and pairs with the serial-in/parallel-out receiver.
- Accepts one parallel word through a valid/ready handshake.
- Shifts the word out one bit per clock with a frame qualifier, then an optional even-parity bit.
- Drives a complementary output pair (sout/sout_n), matching the team's Q/Qn convention.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).
- LSB_FIRST, 0, bit order: 0 = MSB first, 1 = LSB first.
- PARITY_EN, 0, 1 = append one even-parity bit after the data bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  parallel word to transmit
- load_valid  input  1  din is valid this cycle
- load_ready  output  1  transmitter can accept a word this cycle
- sout  output  1  serial data out
- sout_n  output  1  always the complement of sout
- frame  output  1  high while sout carries a data or parity bit
- done  output  1  one-cycle pulse after the last bit of a frame

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register=0, bit counter=0.
  - Outputs: sout=0, sout_n=1, frame=0, done=0, load_ready=1.
  - Reset asserted mid-frame aborts the frame immediately. No done pulse and no partial bits follow once rst deasserts.
- All outputs are registered, except:
  - load_ready, which is decoded from state: it is 1 only in IDLE.
  - sout_n, which is ~sout.
- States: IDLE, SHIFT, PAR.
- IDLE:
  - sout=0, frame=0.
  - Accept happens when load_valid && load_ready at a clock edge. On accept: latch din into the shift register, clear the bit counter, go to SHIFT.
  - load_valid without an accept is ignored. din is sampled only at accept.
- SHIFT:
  - frame=1. sout = current bit: din[WIDTH-1-k] for LSB_FIRST=0, or din[k] for LSB_FIRST=1, where k = bit counter.
  - Counter increments each cycle.
  - When counter = WIDTH-1: go to PAR if PARITY_EN=1, else go to IDLE.
- PAR (PARITY_EN=1 only):
  - frame=1, sout = XOR of all latched bits, so the total number of ones is even.
  - Next state is IDLE.
- Timing:
  - First bit appears on sout in the cycle after accept (latency 1).
  - Frame length is WIDTH + PARITY_EN cycles of frame=1.
- done:
  - Pulses high for exactly one cycle: the first IDLE cycle after a frame.
  - load_ready is also 1 in that cycle.
  - An accept in the done cycle starts the next frame the cycle after. Minimum inter-frame gap is therefore exactly 1 cycle with frame=0.
- Busy behaviour: load_valid while in SHIFT/PAR has no effect. The latched word is unchanged.
- Bit counter width is clog2(WIDTH). It never wraps past WIDTH-1.
- sout_n equals ~sout at all times, including during and immediately after reset.

Test Plan:
1. rst=1 for 10 ns, then 0 -> sout=0, sout_n=1, frame=0, done=0, load_ready=1. Holds until the first accept.
2. Defaults (WIDTH=8, MSB first, no parity), din=8'hA5 accepted at cycle 0:
   - cycles 1..8: frame=1, sout = 1,0,1,0,0,1,0,1 (sout_n the complement).
   - cycle 9: frame=0, done=1, load_ready=1.
3. PARITY_EN=1, LSB_FIRST=1, din=8'h07:
   - sout = 1,1,1,0,0,0,0,0, then parity bit 1 (9 frame cycles).
   - done in cycle 10.
   - Repeat with din=8'hA5 -> parity bit 0.
4. Busy and back-to-back (defaults):
   - Accept 8'hF0, then hold load_valid=1 with din=8'h0F throughout the frame -> load_ready=0 during the frame, and the serialized word is still 8'hF0.
   - In the done cycle, the 8'h0F word is accepted; its first bit (0) appears after exactly one frame=0 cycle.
5. Reset mid-frame: assert rst asynchronously during bit 4 of 8'hFF ->
   - sout=0 and frame=0 immediately, without waiting for a clock edge.
   - After release: no done pulse, load_ready=1.
   - A fresh 8'h81 transmits correctly as 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out framed transmitter with optional even parity.
// Complementary serial outputs; word accepted through a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a word, load_ready=1, line parked low
// SHIFT | data bits on sout, one per clock, frame=1
// PAR   | even-parity bit on sout, frame=1
module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_n,
    output logic             frame,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             parity_q, parity_d;
    logic             sout_q, sout_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;

    // The outgoing bit always sits at the end of the register nearest the line.
    always_comb begin
        if (LSB_FIRST != 0) begin
            shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end else begin
            shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        sout_d   = 1'b0;
        frame_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    shreg_d  = din;
                    parity_d = ^din;
                    cnt_d    = '0;
                    sout_d   = (LSB_FIRST != 0) ? din[0] : din[WIDTH-1];
                    frame_d  = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    if (PARITY_EN != 0) begin
                        sout_d  = parity_q;
                        frame_d = 1'b1;
                        state_d = PAR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shreg_d = shifted;
                    sout_d  = (LSB_FIRST != 0) ? shifted[0] : shifted[WIDTH-1];
                    frame_d = 1'b1;
                end
            end
            PAR: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            sout_q   <= 1'b0;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            sout_q   <= sout_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign sout       = sout_q;
    assign sout_n     = ~sout_q;
    assign frame      = frame_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: three configurations checked against a bit-order /
// parity reference model with randomized words, busy and back-to-back traffic.
module tb_piso_serial_tx;

    localparam int WID [3] = '{8, 8, 5};
    localparam int LSB [3] = '{0, 1, 0};
    localparam int PEN [3] = '{0, 1, 1};

    logic       clk;
    logic       rst;
    logic [7:0] din0;
    logic [7:0] din1;
    logic [4:0] din2;
    logic       lv       [3];
    logic       ready_w  [3];
    logic       sout_w   [3];
    logic       sout_n_w [3];
    logic       frame_w  [3];
    logic       done_w   [3];

    int vec_cnt;
    int err_cnt;

    piso_serial_tx #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(0)) dut_def (
        .clk(clk), .rst(rst), .din(din0), .load_valid(lv[0]), .load_ready(ready_w[0]),
        .sout(sout_w[0]), .sout_n(sout_n_w[0]), .frame(frame_w[0]), .done(done_w[0]));

    piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(1)) dut_lsb_par (
        .clk(clk), .rst(rst), .din(din1), .load_valid(lv[1]), .load_ready(ready_w[1]),
        .sout(sout_w[1]), .sout_n(sout_n_w[1]), .frame(frame_w[1]), .done(done_w[1]));

    piso_serial_tx #(.WIDTH(5), .LSB_FIRST(0), .PARITY_EN(1)) dut_w5_par (
        .clk(clk), .rst(rst), .din(din2), .load_valid(lv[2]), .load_ready(ready_w[2]),
        .sout(sout_w[2]), .sout_n(sout_n_w[2]), .frame(frame_w[2]), .done(done_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int id, input logic [31:0] w);
        case (id)
            0:       din0 = w[7:0];
            1:       din1 = w[7:0];
            default: din2 = w[4:0];
        endcase
    endtask

    // Reference: k-th frame bit of word w for configuration id (data bits, then parity).
    function automatic logic model_bit(input int id, input logic [31:0] w, input int k);
        logic p;
        if (k < WID[id]) begin
            return (LSB[id] != 0) ? w[k] : w[WID[id] - 1 - k];
        end
        p = 1'b0;
        for (int i = 0; i < WID[id]; i++) p = p ^ w[i];
        return p;
    endfunction

    // Transmits one word on configuration id; returns in the done cycle.
    // With busy_hold, load_valid stays high carrying busy_din through the frame.
    task automatic test_frame(input int id, input logic [31:0] w,
                              input bit busy_hold, input logic [31:0] busy_din);
        int   n;
        logic e;
        n = WID[id] + PEN[id];
        set_din(id, w);
        lv[id] = 1'b1;
        vec_cnt++;
        if (ready_w[id] !== 1'b1) begin
            err_cnt++;
            $display("FAIL accept_ready dut%0d: got %b required 1", id, ready_w[id]);
        end
        step();
        if (busy_hold) begin
            set_din(id, busy_din);
        end else begin
            lv[id] = 1'b0;
            set_din(id, $urandom);
        end
        for (int k = 0; k < n; k++) begin
            e = model_bit(id, w, k);
            vec_cnt++;
            if (sout_w[id] !== e || sout_n_w[id] !== ~e || frame_w[id] !== 1'b1 ||
                ready_w[id] !== 1'b0 || done_w[id] !== 1'b0) begin
                err_cnt++;
                $display("FAIL frame_bit dut%0d word %h bit %0d: got sout=%b sout_n=%b frame=%b ready=%b done=%b required sout=%b sout_n=%b frame=1 ready=0 done=0",
                         id, w, k, sout_w[id], sout_n_w[id], frame_w[id], ready_w[id], done_w[id], e, ~e);
            end
            step();
        end
        vec_cnt++;
        if (frame_w[id] !== 1'b0 || done_w[id] !== 1'b1 || ready_w[id] !== 1'b1 ||
            sout_w[id] !== 1'b0 || sout_n_w[id] !== 1'b1) begin
            err_cnt++;
            $display("FAIL done_cycle dut%0d word %h: got frame=%b done=%b ready=%b sout=%b sout_n=%b required 0 1 1 0 1",
                     id, w, frame_w[id], done_w[id], ready_w[id], sout_w[id], sout_n_w[id]);
        end
    endtask

    task automatic check_idle(input string name, input int id);
        vec_cnt++;
        if (sout_w[id] !== 1'b0 || sout_n_w[id] !== 1'b1 || frame_w[id] !== 1'b0 ||
            done_w[id] !== 1'b0 || ready_w[id] !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s dut%0d: got sout=%b sout_n=%b frame=%b done=%b ready=%b required 0 1 0 0 1",
                     name, id, sout_w[id], sout_n_w[id], frame_w[id], done_w[id], ready_w[id]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) lv[i] = 1'b0;
        din0 = 8'h00; din1 = 8'h00; din2 = 5'h00;
        #2;
        for (int i = 0; i < 3; i++) check_idle("reset_active", i);
        #8;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            set_din(c, $urandom);
            for (int i = 0; i < 3; i++) check_idle("reset_hold", i);
        end
    endtask

    task automatic test_fixed_words();
        test_frame(0, 32'hA5, 1'b0, 32'h0);
        step();
        check_idle("done_clears", 0);
        test_frame(1, 32'h07, 1'b0, 32'h0);
        step();
        test_frame(1, 32'hA5, 1'b0, 32'h0);
        step();
        check_idle("done_clears", 1);
    endtask

    task automatic test_busy();
        test_frame(0, 32'hF0, 1'b1, 32'h0F);
        test_frame(0, 32'h0F, 1'b0, 32'h0);
        step();
        check_idle("after_busy", 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] cur, nxt;
        for (int id = 0; id < 3; id++) begin
            cur = $urandom;
            for (int i = 0; i < 4; i++) begin
                nxt = $urandom;
                test_frame(id, cur, (i != 3), nxt);
                cur = nxt;
            end
            step();
            check_idle("b2b_end", id);
        end
    endtask

    task automatic test_random();
        int id, gap;
        for (int i = 0; i < 24; i++) begin
            id = $urandom_range(0, 2);
            test_frame(id, $urandom, 1'b0, 32'h0);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) step();
                check_idle("random_gap", id);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        set_din(0, 32'hFF);
        lv[0] = 1'b1;
        step();
        lv[0] = 1'b0;
        repeat (4) step();
        vec_cnt++;
        if (frame_w[0] !== 1'b1 || sout_w[0] !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_frame_bit4: got frame=%b sout=%b required 1 1", frame_w[0], sout_w[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_abort", 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            check_idle("after_abort", 0);
        end
        test_frame(0, 32'h81, 1'b0, 32'h0);
        step();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_fixed_words();
        test_busy();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
